// File: rtl/fhn_pkg.sv
// rtl/fhn_pkg.sv - shared constants, FSM states and product reduction for the FHN step scheduler
//
// Purpose: Q1.16 number format width, reset/drive constants, sequencer state
//          enum and the 36-bit to 18-bit product reduction used by the
//          shared multiplier.
// Ports:   none (package)

package fhn_pkg;

   localparam int Q_W = 18;

   localparam logic signed [Q_W-1:0] V_RESET = 18'h3_2148;
   localparam logic signed [Q_W-1:0] W_RESET = 18'h3_C9BB;
   localparam logic signed [Q_W-1:0] C_TONIC = 18'h0_2999;
   localparam logic signed [Q_W-1:0] C_BURST = 18'h0_5999;
   localparam logic signed [Q_W-1:0] ACT_AMP = 18'h0_5999;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SNAP,
      ST_M1,
      ST_M2,
      ST_UPD,
      ST_DONE
   } fhn_state_t;

   // Keep the product sign and the 17 bits just above the Q16 binary point.
   function automatic logic signed [Q_W-1:0] q16_reduce(input logic signed [2*Q_W-1:0] p);
      return {p[35], p[32:16]};
   endfunction

endpackage

// File: rtl/fhn_mult_q16.sv
// rtl/fhn_mult_q16.sv - registered signed 18x18 Q1.16 multiplier with reduction
//
// Purpose: one-cycle-latency signed multiply; the reduced product of the
//          operands presented in cycle t is on p in cycle t+1.
// Ports:   CLOCK_50  in   clock, rising edge
//          clear_n   in   synchronous active-low clear of the output register
//          a, b      in   Q1.16 signed operands
//          p         out  registered reduced product, Q1.16 signed

module fhn_mult_q16
   import fhn_pkg::*;
(
   input  logic                  CLOCK_50,
   input  logic                  clear_n,
   input  logic signed [Q_W-1:0] a,
   input  logic signed [Q_W-1:0] b,
   output logic signed [Q_W-1:0] p
);

   logic signed [2*Q_W-1:0] full;

   assign full = a * b;

   always_ff @(posedge CLOCK_50) begin
      if (!clear_n) begin
         p <= '0;
      end else begin
         p <= q16_reduce(full);
      end
   end

endmodule

// File: rtl/fhn_step_scheduler.sv
// rtl/fhn_step_scheduler.sv - time-multiplexed FitzHugh-Nagumo ring step sequencer
//
// Purpose: every PERIOD cycles, snapshot firing flags and walk N neurons
//          through two shared multiplies and one state write-back each.
// Ports:   CLOCK_50    in   clock, rising edge
//          KEY[0]      in   synchronous active-low reset
//          KEY[1]      in   high = tonic drive, low = burst drive (sampled at SNAP)
//          v_bus       out  membrane potentials, neuron i at [18i+17:18i]
//          w_bus       out  recovery variables, same packing
//          active      out  firing flags latched at step start
//          busy        out  high from SNAP through the last UPD
//          step_done   out  one-cycle pulse after the last neuron is written
//          step_count  out  completed steps, wrapping 16-bit counter

module fhn_step_scheduler
   import fhn_pkg::*;
#(
   parameter int N      = 2,
   parameter int PERIOD = 16
)
(
   input  logic              CLOCK_50,
   input  logic [1:0]        KEY,
   output logic [Q_W*N-1:0]  v_bus,
   output logic [Q_W*N-1:0]  w_bus,
   output logic [N-1:0]      active,
   output logic              busy,
   output logic              step_done,
   output logic [15:0]       step_count
);

   if (N < 2) begin : g_bad_n
      $error("fhn_step_scheduler: N must be at least 2");
   end
   if (PERIOD < 3 * N + 2) begin : g_bad_period
      $error("fhn_step_scheduler: PERIOD must be at least 3*N+2");
   end

   localparam int IDX_W = $clog2(N);
   localparam int DIV_W = $clog2(PERIOD);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(PERIOD - 1);

   fhn_state_t state_q;
   fhn_state_t state_d;
   fhn_state_t phase;

   logic [DIV_W-1:0]      div_q;
   logic [IDX_W-1:0]      idx_q;
   logic [IDX_W-1:0]      pred_idx;
   logic                  last;
   logic signed [Q_W-1:0] v_mem [N];
   logic signed [Q_W-1:0] w_mem [N];
   logic signed [Q_W-1:0] c_q;
   logic [N-1:0]          active_q;
   logic [15:0]           count_q;

   logic signed [Q_W-1:0] v_cur;
   logic signed [Q_W-1:0] w_cur;
   logic signed [Q_W-1:0] v_half;
   logic signed [Q_W-1:0] mul_a;
   logic signed [Q_W-1:0] mul_p;
   logic signed [Q_W-1:0] a_term;
   logic signed [Q_W-1:0] dv;
   logic signed [Q_W-1:0] dw;
   logic signed [Q_W-1:0] v_new;
   logic signed [Q_W-1:0] w_new;

   // The SNAP cycle is the idle cycle in which the divider reads zero, so a
   // step starts in the very first cycle out of reset and PERIOD = 3N+2 fits.
   always_comb begin
      phase = state_q;
      if (state_q == ST_IDLE && div_q == '0 && KEY[0]) begin
         phase = ST_SNAP;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!KEY[0]) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      step_done = 1'b0;
      case (phase)
         ST_SNAP: begin
            busy    = 1'b1;
            state_d = ST_M1;
         end
         ST_M1: begin
            busy    = 1'b1;
            state_d = ST_M2;
         end
         ST_M2: begin
            busy    = 1'b1;
            state_d = ST_UPD;
         end
         ST_UPD: begin
            busy    = 1'b1;
            state_d = last ? ST_DONE : ST_M1;
         end
         ST_DONE: begin
            step_done = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath for the neuron currently addressed by idx_q.
   assign last     = (idx_q == LAST_IDX);
   assign pred_idx = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
   assign v_cur    = v_mem[idx_q];
   assign w_cur    = w_mem[idx_q];
   assign v_half   = v_cur >>> 1;

   // M1 squares v against v/2; M2 feeds the fresh v2 back in for v3.
   assign mul_a    = (phase == ST_M2) ? mul_p : v_cur;

   // Coupling reads the flags frozen at SNAP, so visiting order is irrelevant.
   assign a_term   = active_q[pred_idx] ? ACT_AMP : '0;

   // In UPD mul_p holds v3; all sums wrap at 18 bits before shifting.
   assign dv       = (v_cur >>> 2) - mul_p - (w_cur >>> 1) + (c_q >>> 2) - (a_term >>> 2);
   assign v_new    = v_cur + (dv >>> 4);
   assign dw       = v_half - (w_cur >>> 1);
   assign w_new    = w_cur + (dw >>> 9);

   fhn_mult_q16 u_mult (
      .CLOCK_50 (CLOCK_50),
      .clear_n  (KEY[0]),
      .a        (mul_a),
      .b        (v_half),
      .p        (mul_p)
   );

   always_ff @(posedge CLOCK_50) begin
      if (!KEY[0]) begin
         div_q    <= '0;
         idx_q    <= '0;
         c_q      <= '0;
         active_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < N; i++) begin
            v_mem[i] <= V_RESET;
            w_mem[i] <= W_RESET;
         end
      end else begin
         div_q <= (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
         case (phase)
            ST_SNAP: begin
               for (int i = 0; i < N; i++) begin
                  active_q[i] <= v_mem[i][Q_W-1] & v_mem[i][Q_W-2];
               end
               c_q   <= KEY[1] ? C_TONIC : C_BURST;
               idx_q <= '0;
            end
            ST_UPD: begin
               v_mem[idx_q] <= v_new;
               w_mem[idx_q] <= w_new;
               if (last) begin
                  // Count lands together with DONE so consumers see it on step_done.
                  count_q <= count_q + 16'd1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign v_bus[Q_W*g +: Q_W] = v_mem[g];
      assign w_bus[Q_W*g +: Q_W] = w_mem[g];
   end

   assign active     = active_q;
   assign step_count = count_q;

endmodule

// File: tb/tb_fhn_step_scheduler.sv
// tb/tb_fhn_step_scheduler.sv - scoreboard bench for fhn_step_scheduler

module tb_fhn_step_scheduler;

   localparam int N      = 2;
   localparam int PERIOD = 16;
   localparam int W      = 18 * N;

   logic          CLOCK_50 = 1'b0;
   logic [1:0]    KEY      = 2'b10;
   logic [W-1:0]  v_bus;
   logic [W-1:0]  w_bus;
   logic [N-1:0]  active;
   logic          busy;
   logic          step_done;
   logic [15:0]   step_count;

   fhn_step_scheduler #(.N(N), .PERIOD(PERIOD)) dut (
      .CLOCK_50   (CLOCK_50),
      .KEY        (KEY),
      .v_bus      (v_bus),
      .w_bus      (w_bus),
      .active     (active),
      .busy       (busy),
      .step_done  (step_done),
      .step_count (step_count)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit armed    = 0;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   typedef struct {
      int           done_cyc;
      logic [W-1:0] v;
      logic [W-1:0] w;
      logic [N-1:0] act;
      logic [15:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;

   // reference model state
   int mv[N];
   int mw[N];
   int mcount;
   int mdiv;
   int busy_lo = -1;
   int busy_hi = -2;
   int rst_check_cyc = -1;
   bit rk1 = 1'b1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
      end
   endtask

   function automatic int wrap18(input longint x);
      longint m;
      m = x & 64'h3FFFF;
      return (m >= 131072) ? int'(m - 262144) : int'(m);
   endfunction

   // {p[35], p[32:16]} as a signed value: sign weight -2^17 plus 17 bits of floor(p / 2^16)
   function automatic int q16_mul(input int a, input int b);
      longint p;
      longint lo;
      p  = longint'(a) * longint'(b);
      lo = (p >>> 16) & 64'h1FFFF;
      return int'(lo - ((p < 0) ? 64'sd131072 : 64'sd0));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mv[i] = wrap18(64'h32148);
         mw[i] = wrap18(64'h3C9BB);
      end
      mcount = 0;
      mdiv   = 0;
   endtask

   task automatic model_step(input bit k1);
      bit   sact[N];
      int   nv[N];
      int   nw[N];
      int   c;
      exp_t x;
      c = k1 ? 'h2999 : 'h5999;
      for (int i = 0; i < N; i++) sact[i] = (mv[i] < 0) && (mv[i] >= -65536);
      for (int i = 0; i < N; i++) begin
         int v;
         int wv;
         int a;
         int v3;
         int dv;
         int dw;
         v  = mv[i];
         wv = mw[i];
         a  = sact[(i + N - 1) % N] ? 'h5999 : 0;
         v3 = q16_mul(q16_mul(v, v >>> 1), v >>> 1);
         dv = wrap18(longint'((v >>> 2) - v3 - (wv >>> 1) + (c >>> 2) - (a >>> 2)));
         dw = wrap18(longint'((v >>> 1) - (wv >>> 1)));
         nv[i] = wrap18(longint'(v + (dv >>> 4)));
         nw[i] = wrap18(longint'(wv + (dw >>> 9)));
      end
      mcount = (mcount + 1) % 65536;
      x.done_cyc = cyc + 3 * N + 1;
      for (int i = 0; i < N; i++) begin
         mv[i] = nv[i];
         mw[i] = nw[i];
         x.v[18*i +: 18] = 18'(nv[i]);
         x.w[18*i +: 18] = 18'(nw[i]);
         x.act[i] = sact[i];
      end
      x.cnt = 16'(mcount);
      exp_q.push_back(x);
      busy_lo = cyc;
      busy_hi = cyc + 3 * N;
   endtask

   // Drive one cycle's inputs just after the edge and advance the model.
   task automatic drive(input bit k0, input bit k1);
      @(posedge CLOCK_50);
      #1;
      KEY = {k1, k0};
      if (!k0) begin
         while (exp_q.size() > 0 && exp_q[exp_q.size()-1].done_cyc > cyc) void'(exp_q.pop_back());
         if (busy_hi > cyc) busy_hi = cyc;
         model_reset();
         rst_check_cyc = cyc + 1;
      end else begin
         if (mdiv == 0) model_step(k1);
         mdiv = (mdiv + 1) % PERIOD;
      end
   endtask

   // monitor / scoreboard
   always @(negedge CLOCK_50) begin
      if (armed) begin
         while (exp_q.size() > 0 && exp_q[0].done_cyc < cyc) begin
            chk("step_done_cycle", 64'(cyc), 64'(exp_q[0].done_cyc));
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].done_cyc == cyc) begin
            e = exp_q.pop_front();
            chk("step_done", step_done, 1'b1);
            chk("v_bus", v_bus, e.v);
            chk("w_bus", w_bus, e.w);
            chk("active", active, e.act);
            chk("step_count", step_count, e.cnt);
         end else begin
            chk("step_done_idle", step_done, 1'b0);
         end
         chk("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
         if (cyc == rst_check_cyc) begin
            for (int i = 0; i < N; i++) begin
               chk("reset_v", v_bus[18*i +: 18], 18'h32148);
               chk("reset_w", w_bus[18*i +: 18], 18'h3C9BB);
            end
            chk("reset_active", active, '0);
            chk("reset_count", step_count, 16'd0);
         end
      end
   end

   initial begin
      model_reset();

      // reset, then first tonic step with literal expectations
      drive(0, 1);
      drive(0, 1);
      armed = 1'b1;
      drive(0, 1);
      for (int k = 0; k < 8; k++) drive(1, 1);
      @(negedge CLOCK_50);
      chk("tonic_done", step_done, 1'b1);
      chk("tonic_v", v_bus, {18'h32161, 18'h32161});
      chk("tonic_w", w_bus, {18'h3C990, 18'h3C990});
      chk("tonic_active", active, 2'b11);
      chk("tonic_count", step_count, 16'd1);

      // burst drive first step
      drive(0, 0);
      drive(0, 0);
      for (int k = 0; k < 8; k++) drive(1, 0);
      @(negedge CLOCK_50);
      chk("burst_v", v_bus, {18'h32221, 18'h32221});
      chk("burst_w", w_bus, {18'h3C990, 18'h3C990});

      // free-running cadence
      for (int k = 0; k < 40; k++) drive(1, 1);

      // reset after neuron 0 is written
      drive(0, 1);
      drive(0, 1);
      for (int k = 0; k < 4; k++) drive(1, 1);
      drive(0, 1);
      @(negedge CLOCK_50);
      chk("stagger_n0", v_bus[17:0], 18'h32161);
      chk("stagger_n1", v_bus[35:18], 18'h32148);
      for (int k = 0; k < 20; k++) drive(1, 1);

      // randomized drive changes and occasional resets
      for (int n = 0; n < 2500; n++) begin
         bit k0;
         k0 = ($urandom_range(0, 149) != 0);
         if ($urandom_range(0, 7) == 0) rk1 = ~rk1;
         drive(k0, rk1);
      end

      drive(0, 1);
      drive(0, 1);
      @(negedge CLOCK_50);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fhn_step_scheduler.md
# fhn_step_scheduler

Time-multiplexed update sequencer for a ring of N FitzHugh–Nagumo neurons sharing one registered 18×18 signed multiplier. A free-running tick divider starts an integration step every PERIOD cycles. The sequencer snapshots firing flags, then walks the neurons one at a time through two multiplies and one state write-back. It sits between the push-button inputs and the display/DAC logic that samples `v_bus` on `step_done`.

## Interface
- `N`, 2: neuron count (≥2); neuron i is inhibited by neuron (i+N−1) mod N
- `PERIOD`, 16: cycles between step starts; elaboration error if PERIOD < 3N+2
- `CLOCK_50`  in  1  system clock, all logic on rising edge
- `KEY`  in  2  push buttons, active-low. Reset is synchronous and active-low on `KEY[0]`. `KEY[1]` low selects burst drive.
- `v_bus`  out  18N  membrane potentials, neuron i at [18i+17:18i], Q1.16 signed
- `w_bus`  out  18N  recovery variables, same packing
- `active`  out  N  firing flags latched at step start
- `busy`  out  1  high from SNAP through last UPD
- `step_done`  out  1  one-cycle pulse after last neuron written
- `step_count`  out  16  completed steps, wraps 0xFFFF→0

## Operation
- Number format: 18-bit two's complement Q1.16.
- Products: the 36-bit product p is reduced to {p[35], p[32:16]}.
- All adds and subtracts truncate to 18 bits. No saturation. `>>>` is arithmetic.
- Reset (KEY[0]=0 at an edge):
  - every v = 0x3_2148, every w = 0x3_C9BB
  - active = 0, busy = 0, step_done = 0, step_count = 0
  - divider = 0, FSM = IDLE, multiplier output register = 0
  - Reset wins over any in-flight step; a partial step is discarded.
- Divider counts 0..PERIOD−1 and wraps. A step starts when divider==0 and FSM==IDLE.
- FSM: IDLE → SNAP → (M1 → M2 → UPD) × N → DONE → IDLE.
- SNAP:
  - active[i] ← v_i[17] & v_i[16], for every i
  - c ← KEY[1] ? C_TONIC (0x0_2999) : C_BURST (0x0_5999)
  - neuron index ← 0
- M1: issue v·(v>>>1) for the current neuron.
- M2: capture v2 (the M1 result); issue v2·(v>>>1).
- UPD: capture v3 (the M2 result), then write:
  - a = active[pred] ? ACT_AMP (0x0_5999) : 0
  - v ← v + (((v>>>2) − v3 − (w>>>1) + (c>>>2) − (a>>>2)) >>> 4)
  - w ← w + (((v>>>1) − (w>>>1)) >>> 9), using the pre-update v
  - If the index is the last one, go to DONE; otherwise increment the index and go to M1.
- DONE: step_done = 1, step_count += 1, then go to IDLE.
- Coupling always uses the SNAP flags, never flags from earlier neurons updated in the same step. The result is independent of visiting order.
- KEY[1] changes mid-step have no effect until the next SNAP.

## Timing
- Multiplier latency is 1 cycle: operands presented in cycle t, result registered for cycle t+1.
- With SNAP at cycle t0:
  - neuron i runs M1 at t0+1+3i, M2 at t0+2+3i, UPD at t0+3+3i
  - the new v_i/w_i is visible on the buses from t0+4+3i
  - DONE at t0+3N+1; step_done high only in that cycle
  - step_count increments at the same edge
- Neuron values change staggered during a step. Consumers sample only when step_done=1.
- busy is high in cycles t0 .. t0+3N and low in DONE and IDLE.
- The first step begins in the first cycle with KEY[0]=1, since the divider is 0.
- Subsequent SNAPs follow every PERIOD cycles.
- active changes only at SNAP (and at reset).

## Structure
- Package `fhn_pkg` holds:
  - `Q_W` = 18
  - `V_RESET`, `W_RESET`, `C_TONIC`, `C_BURST`, `ACT_AMP`
  - the FSM state enum
  - a function for the product reduction {p[35], p[32:16]}
- Sub-module `fhn_mult_q16`: registered signed 18×18 multiply with the reduction applied; synchronous active-low clear. This is the only multiplier instance.
- State storage: N-entry v/w register arrays indexed by the neuron counter.

## Test plan
- Reset values: hold KEY[0]=0 for 3 cycles → v_bus = {0x3_2148, 0x3_2148}, w_bus = {0x3_C9BB, 0x3_C9BB}, active=0, busy=0, step_count=0.
- First tonic step: N=2, release reset with KEY[1]=1 → active=2'b11 after SNAP; step_done 7 cycles after release; both v=0x3_2161, both w=0x3_C990; step_count=1.
- Burst drive: same as the previous scenario but KEY[1]=0 → both v=0x3_2221 after step 1.
- Period: 40 cycles free-running, PERIOD=16 → step_done exactly every 16 cycles; busy high 7 of 16 cycles.
- Reset mid-step: assert KEY[0] at t0+4 (neuron 0 already written) → next cycle all state equals reset values, FSM IDLE, step_count unchanged at 0, no step_done pulse.
- Counter wrap: preload or run until step_count=0xFFFF → next step_done makes step_count=0x0000.
